jio_ctrl: RTL and testbench
===========================

Name: jio_ctrl

Overview:
- IO controller for the JCSCPU; it replaces the ad-hoc combinational TTY latch in the top level.
- Decodes the CU's IO strobes (io_s, io_e, io_da, io_io) and latches the selected device address.
- Shares the CPU IO port between TTY, LED, switch and key-FIFO devices, and returns read data onto the wired-OR bus.
- Runs on the fast board clock CLK and edge-detects the slow CPU-clock strobes.

Parameters:
FIFO_DEPTH, 4, key FIFO entries; power of two, 2..8
NUM_BTN, 4, number of key event inputs; codes 1..NUM_BTN

Ports:
CLK  in  1  board clock
reset  in  1  synchronous, active-high
io_s  in  1  CU IO set strobe (level, many CLK cycles wide)
io_e  in  1  CU IO enable strobe (level)
io_da  in  1  1 = address cycle, 0 = data cycle
io_io  in  1  1 = output (CPU to device), 0 = input
bus_in  in  8  CPU bus value
bus_out  out  8  read data for wor bus; 0 when not driving
sw  in  16  board switches
btn_evt  in  NUM_BTN  single-CLK key pulses (from click)
tty_out  out  8  TTY value for seven_seg_dec
led_out  out  8  LED register
dev_addr  out  8  currently selected device
key_count  out  4  FIFO occupancy

Behaviour:
- Reset values: tty_out, led_out, dev_addr and key_count are 0; FIFO is empty; overflow is 0; internal edge registers are 0; bus_out is 0.
- Reset wins over every concurrent event, including mid-strobe.
- Strobe detection: wr = io_s & io_io. The write acts in the first CLK cycle in which wr is high and its registered copy is low. The rest of the strobe is ignored. Exactly one action per strobe.
- Address write: wr & io_da. dev_addr <= bus_in on the next edge.
- Data write: wr & ~io_da, decoded on dev_addr:
  - 0: tty_out <= bus_in
  - 1: led_out <= bus_in
  - any other address: ignored
- Read window: rd = io_e & ~io_da & ~io_io.
- bus_out is combinational and valid for the whole window; it is 0 outside rd.
- Read decode on dev_addr:
  - 0: tty_out
  - 1: led_out
  - 2: sw[7:0]
  - 3: sw[15:8]
  - 4: FIFO head; 0x00 if empty
  - 5: status {overflow, full, empty, 1'b0, count[3:0]}
  - any other address: 0x00
- An address read (io_e & io_da & ~io_io) returns 0x00.
- Read side-effects fire once, on the falling edge of rd (registered rd = 1, rd = 0), so data stays stable while the CPU samples it.
  - Addr 4: pop one entry if not empty.
  - Addr 5: clear overflow.
  - The address used is the one held during the window.
- Key push: any btn_evt bit high pushes code = index+1 of the lowest set bit. Other bits in the same cycle are discarded.
- Push when full: data is dropped, overflow <= 1, count is unchanged.
- Push and pop in the same cycle:
  - FIFO non-empty: both happen and count is unchanged.
  - FIFO empty: the push happens and there is no pop.
- Pop on empty: no state change.
- Pointers wrap modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH); empty = (count == 0); key_count = count.
- Write and read strobes are mutually exclusive by io_io. If both appear (illegal), perform the write and ignore the read.

Test Plan:
- Reset, then write addr 0 and data 0x2A (each io_s high 8 CLK cycles) → tty_out = 0x2A exactly once; dev_addr = 0. Repeat with io_s held 100 cycles → no double-write side effects.
- Addr 1, write 0x81; addr 3 with sw = 0xBEEF, read → led_out = 0x81 and bus_out = 0xBE during the window, 0 outside it. Addr 7 read → 0x00.
- Pulse btn_evt = 4'b0100, then 4'b1010 → FIFO holds 3, 2; status = 0x02. Two reads at addr 4 return 0x03 then 0x02, and the popped value is held until the window ends. A third read returns 0x00 and status = 0x20.
- Push 5 keys with FIFO_DEPTH = 4 → status = 0xC4 (overflow, full, count 4). Reading status clears overflow → next status read = 0x44.
- A push and the falling edge of an addr-4 read in the same CLK with count = 2 → count stays 2 and the FIFO order is preserved.
- Assert reset mid-strobe with tty = 0x55 and FIFO count 3 → all outputs 0 next cycle. Keep io_s held through reset release → no write occurs until io_s toggles.

Source files
------------

// File: rtl/jio_ctrl.sv
`timescale 1ns/1ps
// IO controller for the JCSCPU: decodes CU IO strobes, owns the TTY/LED registers,
// exposes switches and a key-event FIFO on the shared CPU IO port.
module jio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_BTN    = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               io_s,
  input  logic               io_e,
  input  logic               io_da,
  input  logic               io_io,
  input  logic [7:0]         bus_in,
  output logic [7:0]         bus_out,
  input  logic [15:0]        sw,
  input  logic [NUM_BTN-1:0] btn_evt,
  output logic [7:0]         tty_out,
  output logic [7:0]         led_out,
  output logic [7:0]         dev_addr,
  output logic [3:0]         key_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 4;

  logic          wr, wr_q, wr_blk, wr_pulse;
  logic          rd, rd_q, rd_fall;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          overflow, fifo_full, fifo_empty;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    push_code;
  logic          push_req, do_push, do_pop, ovf_set, ovf_clr;

  // wr_blk suppresses a strobe that was already high when reset released
  assign wr       = io_s & io_io;
  assign wr_pulse = wr & ~wr_q & ~wr_blk;
  assign rd       = io_e & ~io_da & ~io_io & ~wr;
  assign rd_fall  = rd_q & ~rd;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign key_count  = count;

  // Lowest set event bit wins
  always_comb begin
    push_code = '0;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--)
      if (btn_evt[i]) push_code = 8'(i + 1);
  end

  assign push_req = |btn_evt;
  assign do_pop   = rd_fall & (dev_addr == 8'd4) & ~fifo_empty;
  assign do_push  = push_req & (~fifo_full | do_pop);
  assign ovf_set  = push_req & fifo_full & ~do_pop;
  assign ovf_clr  = rd_fall & (dev_addr == 8'd5);

  always_comb begin
    bus_out = '0;
    if (rd) begin
      case (dev_addr)
        8'd0:    bus_out = tty_out;
        8'd1:    bus_out = led_out;
        8'd2:    bus_out = sw[7:0];
        8'd3:    bus_out = sw[15:8];
        8'd4:    bus_out = fifo_empty ? 8'h00 : mem[rp];
        8'd5:    bus_out = {overflow, fifo_full, fifo_empty, 1'b0, count};
        default: bus_out = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_q     <= 1'b0;
      wr_blk   <= wr;
      rd_q     <= 1'b0;
      dev_addr <= '0;
      tty_out  <= '0;
      led_out  <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_q <= wr;
      rd_q <= rd;
      if (!wr) wr_blk <= 1'b0;
      if (wr_pulse && io_da) dev_addr <= bus_in;
      if (wr_pulse && !io_da) begin
        case (dev_addr)
          8'd0:    tty_out <= bus_in;
          8'd1:    led_out <= bus_in;
          default: ;
        endcase
      end
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge CLK) begin
    if (do_push) mem[wp] <= push_code;
  end

endmodule

// File: tb/tb_jio_ctrl.sv
`timescale 1ns/1ps
// Directed bench for jio_ctrl: expected values go into a scoreboard queue as stimulus
// is applied and are popped against DUT outputs.
module tb_jio_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        io_s, io_e, io_da, io_io;
  logic [7:0]  bus_in, bus_out;
  logic [15:0] sw;
  logic [3:0]  btn_evt;
  logic [7:0]  tty_out, led_out, dev_addr;
  logic [3:0]  key_count;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  sb [$];
  logic [7:0]  r_first, r_last, r_out;

  jio_ctrl #(.FIFO_DEPTH(4), .NUM_BTN(4)) dut (
    .CLK(CLK), .reset(reset), .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io),
    .bus_in(bus_in), .bus_out(bus_out), .sw(sw), .btn_evt(btn_evt),
    .tty_out(tty_out), .led_out(led_out), .dev_addr(dev_addr), .key_count(key_count)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input logic [7:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, observed %02h", tag, obs);
      $fatal(1, "scoreboard underrun");
    end
    exp = sb.pop_front();
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // bus_in is inverted after the first edge so any re-trigger would write a wrong value
  task automatic io_wr(input logic da, input logic [7:0] v, input int hold);
    io_io = 1'b1; io_da = da; bus_in = v; io_s = 1'b1;
    cyc(1);
    bus_in = ~v;
    cyc(hold - 1);
    io_s = 1'b0;
    cyc(2);
  endtask

  task automatic io_rd(input logic da, input logic [3:0] btn_end,
                       output logic [7:0] first, output logic [7:0] last,
                       output logic [7:0] outside);
    io_io = 1'b0; io_da = da; io_e = 1'b1;
    #1 first = bus_out;
    cyc(4);
    last = bus_out;
    io_e = 1'b0; btn_evt = btn_end;
    #1 outside = bus_out;
    cyc(1);
    btn_evt = '0;
    cyc(1);
    io_da = 1'b0;
  endtask

  task automatic push(input logic [3:0] b);
    btn_evt = b;
    cyc(1);
    btn_evt = '0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; io_s = 0; io_e = 0; io_da = 0; io_io = 0; bus_in = 0; sw = 0; btn_evt = 0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    expect_val(8'h00); check("rst_tty", tty_out);
    expect_val(8'h00); check("rst_led", led_out);
    expect_val(8'h00); check("rst_dev", dev_addr);
    expect_val(8'h00); check("rst_cnt", 8'(key_count));
    expect_val(8'h00); check("rst_bus", bus_out);

    // TTY write, short and long strobes
    io_wr(1'b1, 8'h00, 8);
    io_wr(1'b0, 8'h2A, 8);
    expect_val(8'h2A); check("tty_2a", tty_out);
    expect_val(8'h00); check("dev_0", dev_addr);
    io_wr(1'b0, 8'h3C, 100);
    expect_val(8'h3C); check("tty_long", tty_out);

    // LED write, switch read window
    io_wr(1'b1, 8'h01, 8);
    io_wr(1'b0, 8'h81, 8);
    expect_val(8'h81); check("led_81", led_out);
    sw = 16'hBEEF;
    io_wr(1'b1, 8'h03, 8);
    expect_val(8'h00); check("sw_pre", bus_out);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'hBE); check("sw_first", r_first);
    expect_val(8'hBE); check("sw_last", r_last);
    expect_val(8'h00); check("sw_after", r_out);
    io_rd(1'b1, 4'b0, r_first, r_last, r_out);
    expect_val(8'h00); check("addr_read", r_first);
    io_wr(1'b1, 8'h02, 8);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'hEF); check("sw_lo", r_first);
    io_wr(1'b1, 8'h07, 8);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h00); check("addr7", r_first);

    // Key FIFO basic order and status
    push(4'b0100);
    push(4'b1010);
    io_wr(1'b1, 8'h05, 8);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h02); check("stat_2", r_first);
    io_wr(1'b1, 8'h04, 8);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h03); check("pop1_first", r_first);
    expect_val(8'h03); check("pop1_last", r_last);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h02); check("pop2", r_first);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h00); check("pop_empty", r_first);
    expect_val(8'h00); check("cnt_empty", 8'(key_count));
    io_wr(1'b1, 8'h05, 8);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h20); check("stat_empty", r_first);

    // Overflow then clear-on-read
    for (int i = 0; i < 5; i++) push(4'b0001);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'hC4); check("stat_ovf", r_first);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h44); check("stat_clr", r_first);

    // Drain, then concurrent push/pop at count 2
    io_wr(1'b1, 8'h04, 8);
    for (int i = 0; i < 4; i++) begin
      io_rd(1'b0, 4'b0, r_first, r_last, r_out);
      expect_val(8'h01); check("drain", r_first);
    end
    push(4'b1000);
    push(4'b0010);
    expect_val(8'h02); check("cnt_2", 8'(key_count));
    io_rd(1'b0, 4'b0001, r_first, r_last, r_out);
    expect_val(8'h04); check("pp_head", r_first);
    expect_val(8'h02); check("pp_cnt", 8'(key_count));
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h02); check("pp_next", r_first);
    io_rd(1'b0, 4'b0, r_first, r_last, r_out);
    expect_val(8'h01); check("pp_pushed", r_first);

    // Reset mid-strobe, with io_s held across release
    io_wr(1'b1, 8'h00, 8);
    push(4'b0001); push(4'b0001); push(4'b0001);
    expect_val(8'h03); check("pre_cnt", 8'(key_count));
    io_io = 1'b1; io_da = 1'b0; bus_in = 8'h55; io_s = 1'b1;
    cyc(3);
    expect_val(8'h55); check("pre_tty", tty_out);
    reset = 1'b1;
    cyc(1);
    expect_val(8'h00); check("mid_tty", tty_out);
    expect_val(8'h00); check("mid_cnt", 8'(key_count));
    expect_val(8'h00); check("mid_dev", dev_addr);
    expect_val(8'h00); check("mid_led", led_out);
    expect_val(8'h00); check("mid_bus", bus_out);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    expect_val(8'h00); check("held_nowr", tty_out);
    io_s = 1'b0;
    cyc(2);
    io_s = 1'b1;
    cyc(2);
    io_s = 1'b0;
    cyc(2);
    expect_val(8'h55); check("retoggle", tty_out);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
